// File: rtl/tank_pkg.sv
// Shared types and constants for the tank game fire control path.
// Used by shell_fire_ctrl and fire_channel.
package tank_pkg;

   typedef enum logic [1:0] {
      StReady = 2'd0,
      StFire  = 2'd1,
      StCool  = 2'd2
   } fire_state_t;

   localparam int unsigned SHELL_NUM = 5;
   localparam int unsigned AMMO_W    = 3;

endpackage

// File: rtl/fire_channel.sv
// One player's fire scheduler: trigger detect, READY/FIRE/COOL FSM, cooldown and ammo reload.
// Define SHELL_FIRE_AUTOREPEAT_EN to fire on button level instead of rising edge.
module fire_channel
   import tank_pkg::*;
#(
   parameter int unsigned COOLDOWN = 4_000_000,
   parameter int unsigned RELOAD   = 25_000_000,
   parameter int unsigned AMMO_MAX = 5
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 game_active,
   input  logic                 btn,
   input  logic [SHELL_NUM-1:0] shell_free,
   output logic                 fire,
   output logic [AMMO_W-1:0]    ammo,
   output logic                 busy
);

   localparam int unsigned CD_W = $clog2(COOLDOWN + 1);
   localparam int unsigned RL_W = $clog2(RELOAD + 1);

   localparam logic [CD_W-1:0]   CD_LOAD   = CD_W'(COOLDOWN - 1);
   localparam logic [RL_W-1:0]   RL_LAST   = RL_W'(RELOAD - 1);
   localparam logic [AMMO_W-1:0] AMMO_FULL = AMMO_W'(AMMO_MAX);

   fire_state_t       state_q, state_d;
   logic              btn_q;
   logic [CD_W-1:0]   cd_q, cd_d;
   logic [RL_W-1:0]   rl_q, rl_d;
   logic [AMMO_W-1:0] ammo_q, ammo_d;

   logic trig;
   logic fire_go;
   logic full;
   logic reload_tick;

`ifdef SHELL_FIRE_AUTOREPEAT_EN
   // Level trigger; the edge term keeps fresh presses behaving as in the edge build.
   assign trig = btn | (btn & ~btn_q);
`else
   assign trig = btn & ~btn_q;
`endif

   assign fire_go = game_active && (state_q == StReady) && trig &&
                    (ammo_q != '0) && (|shell_free);

   assign full        = (ammo_q >= AMMO_FULL);
   assign reload_tick = !full && (rl_q == RL_LAST);

   // State register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= StReady;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic; a dropped round forces READY regardless of state
   always_comb begin
      state_d = state_q;
      if (!game_active) begin
         state_d = StReady;
      end else begin
         case (state_q)
            StReady: if (fire_go) state_d = StFire;
            StFire:  state_d = StCool;
            StCool:  if (cd_q == '0) state_d = StReady;
            default: state_d = StReady;
         endcase
      end
   end

   // Outputs decoded straight from the state register
   always_comb begin
      fire = 1'b0;
      busy = 1'b0;
      case (state_q)
         StFire:  begin fire = 1'b1; busy = 1'b1; end
         StCool:  busy = 1'b1;
         default: ;
      endcase
   end

   always_comb begin
      cd_d = cd_q;
      if (!game_active) begin
         cd_d = '0;
      end else if (state_q == StFire) begin
         cd_d = CD_LOAD;
      end else if ((state_q == StCool) && (cd_q != '0)) begin
         cd_d = cd_q - 1'b1;
      end
   end

   // A shot and a reload tick on the same edge cancel; the reload counter still clears.
   always_comb begin
      rl_d   = rl_q;
      ammo_d = ammo_q;
      if (!game_active) begin
         rl_d   = '0;
         ammo_d = AMMO_FULL;
      end else begin
         if (full || reload_tick) begin
            rl_d = '0;
         end else begin
            rl_d = rl_q + 1'b1;
         end
         case ({fire_go, reload_tick})
            2'b10:   ammo_d = ammo_q - 1'b1;
            2'b01:   ammo_d = ammo_q + 1'b1;
            default: ammo_d = ammo_q;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         btn_q  <= 1'b0;
         cd_q   <= '0;
         rl_q   <= '0;
         ammo_q <= AMMO_FULL;
      end else begin
         btn_q  <= btn;
         cd_q   <= cd_d;
         rl_q   <= rl_d;
         ammo_q <= ammo_d;
      end
   end

   assign ammo = ammo_q;

endmodule

// File: rtl/shell_fire_ctrl.sv
// Two independent fire channels feeding the shell block and the ammo HUD.
// Define SHELL_FIRE_AUTOREPEAT_EN to enable hold-to-repeat firing.
module shell_fire_ctrl
   import tank_pkg::*;
#(
   parameter int unsigned COOLDOWN = 4_000_000,
   parameter int unsigned RELOAD   = 25_000_000,
   parameter int unsigned AMMO_MAX = 5
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 game_active,
   input  logic                 btn_1,
   input  logic                 btn_2,
   input  logic [SHELL_NUM-1:0] shell_free_1,
   input  logic [SHELL_NUM-1:0] shell_free_2,
   output logic                 fire_1,
   output logic                 fire_2,
   output logic                 valid_give_shell_1,
   output logic                 valid_give_shell_2,
   output logic [AMMO_W-1:0]    ammo_1,
   output logic [AMMO_W-1:0]    ammo_2,
   output logic                 busy_1,
   output logic                 busy_2
);

   fire_channel #(
      .COOLDOWN (COOLDOWN),
      .RELOAD   (RELOAD),
      .AMMO_MAX (AMMO_MAX)
   ) u_chan_1 (
      .clk         (clk),
      .rst         (rst),
      .game_active (game_active),
      .btn         (btn_1),
      .shell_free  (shell_free_1),
      .fire        (fire_1),
      .ammo        (ammo_1),
      .busy        (busy_1)
   );

   fire_channel #(
      .COOLDOWN (COOLDOWN),
      .RELOAD   (RELOAD),
      .AMMO_MAX (AMMO_MAX)
   ) u_chan_2 (
      .clk         (clk),
      .rst         (rst),
      .game_active (game_active),
      .btn         (btn_2),
      .shell_free  (shell_free_2),
      .fire        (fire_2),
      .ammo        (ammo_2),
      .busy        (busy_2)
   );

   assign valid_give_shell_1 = fire_1;
   assign valid_give_shell_2 = fire_2;

endmodule

// File: tb/tb_shell_fire_ctrl.sv
// Directed bench for shell_fire_ctrl with COOLDOWN=4, RELOAD=10, AMMO_MAX=5 (edge-trigger build).
module tb_shell_fire_ctrl;

   localparam int unsigned COOLDOWN = 4;
   localparam int unsigned RELOAD   = 10;
   localparam int unsigned AMMO_MAX = 5;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       game_active = 1'b0;
   logic       btn_1 = 1'b0;
   logic       btn_2 = 1'b0;
   logic [4:0] shell_free_1 = 5'h1F;
   logic [4:0] shell_free_2 = 5'h1F;
   logic       fire_1, fire_2, valid_give_shell_1, valid_give_shell_2, busy_1, busy_2;
   logic [2:0] ammo_1, ammo_2;

   int n_checks = 0;
   int n_errors = 0;

   // Ammo after each of ten shots spaced 6 cycles apart, starting from a full magazine.
   logic [7:0] exp_ammo [10] = '{8'd4, 8'd3, 8'd3, 8'd2, 8'd2, 8'd2, 8'd1, 8'd1, 8'd0, 8'd0};

   always #5 clk = ~clk;

   shell_fire_ctrl #(
      .COOLDOWN (COOLDOWN),
      .RELOAD   (RELOAD),
      .AMMO_MAX (AMMO_MAX)
   ) dut (
      .clk                (clk),
      .rst                (rst),
      .game_active        (game_active),
      .btn_1              (btn_1),
      .btn_2              (btn_2),
      .shell_free_1       (shell_free_1),
      .shell_free_2       (shell_free_2),
      .fire_1             (fire_1),
      .fire_2             (fire_2),
      .valid_give_shell_1 (valid_give_shell_1),
      .valid_give_shell_2 (valid_give_shell_2),
      .ammo_1             (ammo_1),
      .ammo_2             (ammo_2),
      .busy_1             (busy_1),
      .busy_2             (busy_2)
   );

   task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   initial begin
      tick(2);
      check("rst_fire_1", 8'(fire_1), 8'd0);
      check("rst_fire_2", 8'(fire_2), 8'd0);
      check("rst_valid_1", 8'(valid_give_shell_1), 8'd0);
      check("rst_busy_1", 8'(busy_1), 8'd0);
      check("rst_busy_2", 8'(busy_2), 8'd0);
      check("rst_ammo_1", 8'(ammo_1), 8'd5);
      check("rst_ammo_2", 8'(ammo_2), 8'd5);

      rst = 1'b0;
      game_active = 1'b1;
      tick(1);

      // Single press
      btn_1 = 1'b1;
      tick(1);
      check("press_fire_1", 8'(fire_1), 8'd1);
      check("press_valid_1", 8'(valid_give_shell_1), 8'd1);
      check("press_ammo_1", 8'(ammo_1), 8'd4);
      check("press_busy_1", 8'(busy_1), 8'd1);
      check("press_fire_2", 8'(fire_2), 8'd0);
      btn_1 = 1'b0;
      tick(1);
      check("pulse_end_fire_1", 8'(fire_1), 8'd0);
      check("pulse_end_valid_1", 8'(valid_give_shell_1), 8'd0);
      check("cool_busy_1", 8'(busy_1), 8'd1);

      // Press during cooldown is dropped
      tick(1);
      btn_1 = 1'b1;
      tick(1);
      check("cool_press_fire_1", 8'(fire_1), 8'd0);
      check("cool_press_ammo_1", 8'(ammo_1), 8'd4);
      tick(1);
      check("cool_last_busy_1", 8'(busy_1), 8'd1);
      btn_1 = 1'b0;
      tick(1);
      check("ready_busy_1", 8'(busy_1), 8'd0);

      // Press after busy falls
      btn_1 = 1'b1;
      tick(1);
      check("repress_fire_1", 8'(fire_1), 8'd1);
      check("repress_ammo_1", 8'(ammo_1), 8'd3);
      btn_1 = 1'b0;
      tick(1);
      check("repress_cool_busy_1", 8'(busy_1), 8'd1);
      tick(1);

      // Drop the round mid-cooldown
      game_active = 1'b0;
      tick(1);
      check("gameoff_busy_1", 8'(busy_1), 8'd0);
      check("gameoff_fire_1", 8'(fire_1), 8'd0);
      check("gameoff_ammo_1", 8'(ammo_1), 8'd5);

      // Drain ammo with shots every 6 cycles while reload ticks every 10
      game_active = 1'b1;
      for (int i = 0; i < 10; i++) begin
         btn_1 = 1'b1;
         tick(1);
         check($sformatf("drain_fire_%0d", i), 8'(fire_1), 8'd1);
         check($sformatf("drain_ammo_%0d", i), 8'(ammo_1), exp_ammo[i]);
         btn_1 = 1'b0;
         tick(5);
      end
      check("empty_ammo_1", 8'(ammo_1), 8'd0);
      check("empty_busy_1", 8'(busy_1), 8'd0);

      // Empty press: no shot, and this edge's reload tick brings ammo to 1
      btn_1 = 1'b1;
      tick(1);
      check("empty_press_fire_1", 8'(fire_1), 8'd0);
      check("empty_press_busy_1", 8'(busy_1), 8'd0);
      check("reload_ammo_1", 8'(ammo_1), 8'd1);
      btn_1 = 1'b0;

      // No free shell on player 2
      shell_free_2 = 5'b00000;
      btn_2 = 1'b1;
      tick(1);
      check("noshell_fire_2", 8'(fire_2), 8'd0);
      check("noshell_valid_2", 8'(valid_give_shell_2), 8'd0);
      check("noshell_busy_2", 8'(busy_2), 8'd0);
      check("noshell_ammo_2", 8'(ammo_2), 8'd5);
      btn_2 = 1'b0;
      shell_free_2 = 5'b00100;
      tick(1);

      // Both players on the same edge
      btn_1 = 1'b1;
      btn_2 = 1'b1;
      tick(1);
      check("both_fire_1", 8'(fire_1), 8'd1);
      check("both_fire_2", 8'(fire_2), 8'd1);
      check("both_valid_1", 8'(valid_give_shell_1), 8'd1);
      check("both_valid_2", 8'(valid_give_shell_2), 8'd1);
      check("both_ammo_1", 8'(ammo_1), 8'd0);
      check("both_ammo_2", 8'(ammo_2), 8'd4);
      btn_1 = 1'b0;
      btn_2 = 1'b0;
      tick(1);
      check("both_cool_busy_1", 8'(busy_1), 8'd1);
      check("both_cool_busy_2", 8'(busy_2), 8'd1);

      // Asynchronous reset mid-cooldown, sampled before any clock edge
      #3 rst = 1'b1;
      #1;
      check("arst_busy_1", 8'(busy_1), 8'd0);
      check("arst_busy_2", 8'(busy_2), 8'd0);
      check("arst_ammo_1", 8'(ammo_1), 8'd5);
      check("arst_ammo_2", 8'(ammo_2), 8'd5);
      check("arst_fire_1", 8'(fire_1), 8'd0);

      tick(1);
      rst = 1'b0;
      shell_free_1 = 5'b10000;
      btn_1 = 1'b1;
      tick(1);
      check("post_rst_fire_1", 8'(fire_1), 8'd1);
      check("post_rst_ammo_1", 8'(ammo_1), 8'd4);
      btn_1 = 1'b0;
      tick(1);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/shell_fire_ctrl.md
# shell_fire_ctrl

Schedules shell firing for both tanks. It turns raw player fire buttons into single-cycle `fire_1`/`fire_2` and `valid_give_shell_1`/`valid_give_shell_2` requests for the shell block. Each player gets an enforced cooldown between shots and a finite, slowly reloading ammo count. It sits between the game/input logic and the shell block, and feeds back ammo status for the VGA HUD.

## Interface
- `COOLDOWN`, default 4_000_000: cycles a channel stays busy after a shot (≥1).
- `RELOAD`, default 25_000_000: cycles per regained round while ammo < AMMO_MAX (≥1).
- `AMMO_MAX`, default 5: ammo capacity per player (1..7).

Ports:
- `clk`  in  1  system clock.
- `rst`  in  1  asynchronous, active-high reset.
- `game_active`  in  1  high while a round is in play.
- `btn_1`, `btn_2`  in  1 each  player fire buttons, already synchronised to `clk`, level.
- `shell_free_1`, `shell_free_2`  in  5 each  per-shell idle flags from the shell block; 1 means idle.
- `fire_1`, `fire_2`  out  1 each  one-cycle fire request to the shell block.
- `valid_give_shell_1`, `valid_give_shell_2`  out  1 each  equal to the matching `fire_x`, so the shell block sees a qualified request.
- `ammo_1`, `ammo_2`  out  3 each  current rounds.
- `busy_1`, `busy_2`  out  1 each  channel is in FIRE or COOL.

## Operation
- The two channels are identical and independent. There is no arbitration between players; both may fire in the same cycle.
- Per-channel FSM:
  - READY → FIRE when `game_active` & `trig` & `ammo>0` & `|shell_free`.
  - FIRE → COOL unconditionally after 1 cycle.
  - COOL → READY when the cooldown counter reaches 0.
- `trig`:
  - Base build: rising edge, `btn & ~btn_q`, where `btn_q` is the registered previous sample.
  - See Configuration for the auto-repeat variant.
  - An edge that arrives in FIRE or COOL is discarded, not queued.
- `fire_x` is 1 exactly while the state is FIRE.
- Cooldown counter:
  - Loaded with COOLDOWN-1 on FIRE→COOL.
  - Decrements every cycle in COOL.
  - Width is $clog2(COOLDOWN+1).
- Ammo accounting:
  - Ammo decrements on entry to FIRE.
  - Reload counter runs only while ammo < AMMO_MAX. On reaching RELOAD-1 it clears and ammo increments.
  - If a decrement and an increment land on the same edge, ammo is unchanged and the reload counter still clears.
  - When ammo = AMMO_MAX the reload counter is held at 0.
  - Ammo never underflows or exceeds AMMO_MAX.
- `game_active` low, sampled at any edge:
  - State → READY, counters → 0, ammo → AMMO_MAX.
  - `fire_x` is forced 0 from the next cycle.
  - `btn_q` continues tracking `btn`.
- `shell_free = 0` (all 5 shells in flight) blocks firing. Ammo is not consumed.

## Timing
- Reset values:
  - State READY.
  - `fire_x`, `valid_give_shell_x`, `busy_x` = 0.
  - `ammo_x` = AMMO_MAX.
  - All counters 0, `btn_q` = 0.
- Latency: `btn` first sampled high at edge k (READY, conditions met) gives `fire_x` high from edge k to edge k+1, i.e. a 1-cycle registered pulse.
- Fire pulse spacing: the minimum gap between `fire_x` rising edges is COOLDOWN+1 cycles.
- Outputs are all registered or decoded directly from state registers. There is no combinational path from the inputs.
- Reset mid-cooldown or mid-FIRE:
  - Immediate asynchronous return to the reset values.
  - A pulse that is cut short is allowed.

## Configuration
- `SHELL_FIRE_AUTOREPEAT_EN` defined:
  - `trig` = `btn` level.
  - Holding the button fires every COOLDOWN+1 cycles while ammo and shells allow.
  - Rising edges still fire normally.
- Undefined:
  - Edge-only `trig`; one shot per press.
  - Holding the button through COOL does not re-fire.

## Structure
- Shared package `tank_pkg`:
  - `fire_state_t` enum: READY=2'd0, FIRE=2'd1, COOL=2'd2.
  - `SHELL_NUM` = 5.
  - `AMMO_W` = 3.
- Sub-module `fire_channel` holds the FSM, edge register, cooldown counter and ammo/reload logic.
- The top instantiates `fire_channel` twice and holds the `game_active` fan-out.

## Test plan
All scenarios use COOLDOWN=4, RELOAD=10, AMMO_MAX=5.

- **Single press:** reset, `game_active`=1, `shell_free`=5'b11111, raise `btn_1` → `fire_1`/`valid_give_shell_1` high exactly 1 cycle, one cycle after the sample; `ammo_1` goes 5→4; `busy_1` high 5 cycles.
- **Press during cooldown:** second press 2 cycles after the pulse → no pulse. Press after `busy_1` falls → pulse.
- **Ammo and reload:**
  - 5 spaced presses → `ammo_1`=0.
  - A 6th press → no pulse.
  - After 10 cycles → `ammo_1`=1.
  - A simultaneous shot and reload tick leaves ammo unchanged.
- **Resource and round gating:**
  - `shell_free_2`=0 with a press → no `fire_2`, `ammo_2` stays 5.
  - Dropping `game_active` mid-COOL → READY and ammo 5 on the next cycle.
- **Both players:** press `btn_1` and `btn_2` on the same edge → both fire the same cycle.
- **Asynchronous reset:** assert `rst` mid-cooldown → outputs return to reset values without a clock edge. With `SHELL_FIRE_AUTOREPEAT_EN` and a held button → pulses every 5 cycles until ammo is 0.
